modexp_param: RTL and testbench

Parametrised, bit-serial modular exponentiation engine that computes cypher = message^exponent mod modulus for any nonzero modulus, odd or even. It is the width-generic successor of the fixed 4096-bit RSA core and keeps the same go/done handshake. It adds abort, error reporting, leading-zero exponent skipping and a compile-time constant-time mode. It uses one shared interleaved shift-add-subtract modular multiplier.

---
 rtl/modexp_if.sv | 29 ++
 rtl/modexp_param.sv | 182 ++++++++++++++++++
 tb/tb_modexp_param.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/modexp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// modexp_if - operand/result bus and go/done handshake for modexp_param
// Rev 1.0
// ---------------------------------------------------------------------------
interface modexp_if #(
   parameter int WIDTH     = 4096,
   parameter int EXP_WIDTH = WIDTH
);
   logic                 go;
   logic [WIDTH-1:0]     message;
   logic [EXP_WIDTH-1:0] exponent;
   logic [WIDTH-1:0]     modulus;
   logic [WIDTH-1:0]     cypher;
   logic                 done;
   logic                 busy;
   logic                 err;

   modport master (
      output go, message, exponent, modulus,
      input  cypher, done, busy, err
   );

   modport slave (
      input  go, message, exponent, modulus,
      output cypher, done, busy, err
   );
endinterface
`default_nettype wire

// File: rtl/modexp_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// modexp_param - bit-serial cypher = message^exponent mod modulus, any nonzero
// modulus. Define MODEXP_CONST_TIME_EN for a fixed, data-independent latency.
// Rev 1.0
// ---------------------------------------------------------------------------
module modexp_param #(
   parameter int WIDTH     = 4096,
   parameter int EXP_WIDTH = WIDTH
) (
   input  logic    clk,
   input  logic    reset,
   modexp_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam int AW    = WIDTH + 2;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REDUCE = 3'd1,
      S_SQR    = 3'd2,
      S_MUL    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     msg_q, mod_q, base_q, r_q, cypher_q;
   logic [EXP_WIDTH-1:0] exp_q;
   logic [AW-1:0]        acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 err_q;

   logic [IDX_W-1:0]     idx_start;
   logic                 last_bit, cur_bit, idx_zero;
   logic [AW-1:0]        mod_ext, addend, sum, sub1, sub2;

   assign last_bit = (cnt_q == '0);
   assign cur_bit  = exp_q[idx_q];
   assign idx_zero = (idx_q == '0);

`ifdef MODEXP_CONST_TIME_EN
   assign idx_start = IDX_W'(EXP_WIDTH - 1);
`else
   // Scan begins at the most significant set exponent bit.
   always_comb begin
      idx_start = '0;
      for (int i = 0; i < EXP_WIDTH; i++) begin
         if (bus.exponent[i]) idx_start = IDX_W'(i);
      end
   end
`endif

   // Shared serial step: REDUCE feeds message bits, SQR/MUL feed R or base
   // gated by the current bit of R. 2*acc + b < 3N, so two subtracts suffice.
   always_comb begin
      mod_ext = {2'b00, mod_q};
      addend  = '0;
      if (state_q == S_REDUCE) begin
         addend = AW'(msg_q[cnt_q]);
      end else if (r_q[cnt_q]) begin
         addend = (state_q == S_MUL) ? {2'b00, base_q} : {2'b00, r_q};
      end
      sum  = (acc_q << 1) + addend;
      sub1 = (sum  >= mod_ext) ? sum  - mod_ext : sum;
      sub2 = (sub1 >= mod_ext) ? sub1 - mod_ext : sub1;
   end

   always_comb begin
      state_d = state_q;
      busy_d  = 1'b0;
      done_d  = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (bus.go) state_d = (bus.modulus == '0) ? S_DONE : S_REDUCE;
         end
         S_REDUCE: begin
            busy_d = bus.go;
            if (!bus.go) begin
               state_d = S_IDLE;
            end else if (last_bit) begin
`ifdef MODEXP_CONST_TIME_EN
               state_d = S_SQR;
`else
               state_d = (exp_q == '0) ? S_DONE : S_SQR;
`endif
            end
         end
         S_SQR: begin
            busy_d = bus.go;
            if (!bus.go) begin
               state_d = S_IDLE;
            end else if (last_bit) begin
`ifdef MODEXP_CONST_TIME_EN
               state_d = S_MUL;
`else
               if (cur_bit)       state_d = S_MUL;
               else if (idx_zero) state_d = S_DONE;
               else               state_d = S_SQR;
`endif
            end
         end
         S_MUL: begin
            busy_d = bus.go;
            if (!bus.go) begin
               state_d = S_IDLE;
            end else if (last_bit) begin
               state_d = idx_zero ? S_DONE : S_SQR;
            end
         end
         S_DONE: begin
            if (!bus.go) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         msg_q    <= '0;
         mod_q    <= '0;
         base_q   <= '0;
         r_q      <= '0;
         cypher_q <= '0;
         exp_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         case (state_q)
            S_IDLE: begin
               if (bus.go) begin
                  msg_q <= bus.message;
                  exp_q <= bus.exponent;
                  mod_q <= bus.modulus;
                  err_q <= (bus.modulus == '0);
                  // 1 mod N is 0 for N==1; N==0 also reports 0.
                  r_q   <= (bus.modulus <= WIDTH'(1)) ? '0 : WIDTH'(1);
                  acc_q <= '0;
                  cnt_q <= CNT_TOP;
                  idx_q <= idx_start;
               end
            end
            S_REDUCE, S_SQR, S_MUL: begin
               acc_q <= sub2;
               cnt_q <= cnt_q - CNT_W'(1);
               if (last_bit) begin
                  acc_q <= '0;
                  cnt_q <= CNT_TOP;
                  if (state_q == S_REDUCE) begin
                     base_q <= sub2[WIDTH-1:0];
                  end else if (state_q == S_SQR || cur_bit) begin
                     r_q <= sub2[WIDTH-1:0];
                  end
                  if (state_d == S_SQR && state_q != S_REDUCE) begin
                     idx_q <= idx_q - IDX_W'(1);
                  end
               end
            end
            S_DONE: cypher_q <= r_q;
            default: ;
         endcase
      end
   end

   assign bus.cypher = cypher_q;
   assign bus.done   = done_q;
   assign bus.busy   = busy_q;
   assign bus.err    = err_q;
endmodule
`default_nettype wire

// File: tb/tb_modexp_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_modexp_param - directed vectors and handshake corner cases for modexp_param
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_modexp_param;
   localparam int W   = 16;
   localparam int WB  = 4096;
   localparam int EWB = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   modexp_if #(.WIDTH(W), .EXP_WIDTH(W)) bus ();
   modexp_param #(.WIDTH(W), .EXP_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   modexp_if #(.WIDTH(WB), .EXP_WIDTH(EWB)) busb ();
   modexp_param #(.WIDTH(WB), .EXP_WIDTH(EWB)) dutb (
      .clk   (clk),
      .reset (reset),
      .bus   (busb)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] msg;
      logic [15:0] expo;
      logic [15:0] modu;
      logic [15:0] cyp;
      logic        err;
      int          cyc_def;
   } vec_t;

   vec_t vecs[6];

   function automatic int exp_cycles(input vec_t v);
`ifdef MODEXP_CONST_TIME_EN
      return (v.modu == 16'd0) ? 1 : W * (1 + 2 * W) + 1;
`else
      return v.cyc_def;
`endif
   endfunction

   task automatic start_run(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n,
                            output int cyc, output logic busy_seen);
      @(negedge clk);
      bus.message  = m;
      bus.exponent = e;
      bus.modulus  = n;
      bus.go       = 1'b1;
      @(posedge clk);
      cyc       = 0;
      busy_seen = 1'b0;
      while (cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.busy) busy_seen = 1'b1;
         if (bus.done) break;
      end
   endtask

   task automatic release_go();
      @(negedge clk);
      bus.go = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   int   cyc;
   logic bseen;

   initial begin
      vecs[0] = '{16'd8,    16'd13, 16'd77, 16'd50, 1'b0, 129};
      vecs[1] = '{16'd50,   16'd37, 16'd77, 16'd8,  1'b0, 161};
      vecs[2] = '{16'd85,   16'd1,  16'd77, 16'd8,  1'b0, 49};
      vecs[3] = '{16'd123,  16'd0,  16'd77, 16'd1,  1'b0, 17};
      vecs[4] = '{16'd1234, 16'd5,  16'd1,  16'd0,  1'b0, 97};
      vecs[5] = '{16'd9,    16'd3,  16'd0,  16'd0,  1'b1, 1};

      reset = 1'b0;
      bus.go = 1'b0; bus.message = '0; bus.exponent = '0; bus.modulus = '0;
      busb.go = 1'b0; busb.message = '0; busb.exponent = '0; busb.modulus = '0;
      #13;
      check("rst_cypher", 64'(bus.cypher), 64'd0);
      check("rst_done",   64'(bus.done),   64'd0);
      check("rst_busy",   64'(bus.busy),   64'd0);
      check("rst_err",    64'(bus.err),    64'd0);
      #10 reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         start_run(vecs[i].msg, vecs[i].expo, vecs[i].modu, cyc, bseen);
         check($sformatf("v%0d_cypher", i), 64'(bus.cypher), 64'(vecs[i].cyp));
         check($sformatf("v%0d_err", i),    64'(bus.err),    64'(vecs[i].err));
         check($sformatf("v%0d_cycles", i), 64'(cyc),        64'(exp_cycles(vecs[i])));
         check($sformatf("v%0d_busy_seen", i), 64'(bseen),  64'(vecs[i].modu != 16'd0));
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("v%0d_done_held", i), 64'(bus.done), 64'd1);
         check($sformatf("v%0d_no_retrig", i), 64'(bus.busy), 64'd0);
         release_go();
         check($sformatf("v%0d_done_clear", i), 64'(bus.done), 64'd0);
      end

      // Abort 50 cycles into 8^13; cypher still holds 0 from the modulus==0 run.
      @(negedge clk);
      bus.message = 16'd8; bus.exponent = 16'd13; bus.modulus = 16'd77; bus.go = 1'b1;
      @(posedge clk);
      repeat (50) @(posedge clk);
      #1;
      check("abort_busy_before", 64'(bus.busy), 64'd1);
      @(negedge clk);
      bus.go = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy_fall", 64'(bus.busy),   64'd0);
      check("abort_done",      64'(bus.done),   64'd0);
      check("abort_cypher",    64'(bus.cypher), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("abort_done_later", 64'(bus.done), 64'd0);
      start_run(16'd8, 16'd13, 16'd77, cyc, bseen);
      check("restart_cypher", 64'(bus.cypher), 64'd50);
      check("restart_cycles", 64'(cyc), 64'(exp_cycles(vecs[0])));

      // Asynchronous reset while in DONE.
      #2 reset = 1'b0;
      #1;
      check("rst_done_cypher", 64'(bus.cypher), 64'd0);
      check("rst_done_done",   64'(bus.done),   64'd0);
      bus.go = 1'b0;
      @(negedge clk) reset = 1'b1;

      // Asynchronous reset with err set.
      start_run(16'd3, 16'd3, 16'd0, cyc, bseen);
      check("err_before_rst", 64'(bus.err), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_err_clear", 64'(bus.err), 64'd0);
      bus.go = 1'b0;
      @(negedge clk) reset = 1'b1;

      // Asynchronous reset mid-run.
      @(negedge clk);
      bus.message = 16'd50; bus.exponent = 16'd37; bus.modulus = 16'd77; bus.go = 1'b1;
      @(posedge clk);
      repeat (30) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_busy",   64'(bus.busy),   64'd0);
      check("rst_mid_done",   64'(bus.done),   64'd0);
      check("rst_mid_cypher", 64'(bus.cypher), 64'd0);
      bus.go = 1'b0;
      @(negedge clk) reset = 1'b1;
      start_run(16'd8, 16'd13, 16'd77, cyc, bseen);
      check("post_rst_cypher", 64'(bus.cypher), 64'd50);
      check("post_rst_cycles", 64'(cyc), 64'(exp_cycles(vecs[0])));
      release_go();

      // Wide instance: 50^37 mod 77 with WIDTH=4096, EXP_WIDTH=6.
      @(negedge clk);
      busb.message = WB'(50); busb.exponent = EWB'(37); busb.modulus = WB'(77); busb.go = 1'b1;
      @(posedge clk);
      cyc = 0;
      while (cyc < 60000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busb.done) break;
      end
      check("wide_cypher_is_8", 64'(busb.cypher == WB'(8)), 64'd1);
      check("wide_err", 64'(busb.err), 64'd0);
`ifdef MODEXP_CONST_TIME_EN
      check("wide_cycles", 64'(cyc), 64'(WB * (1 + 2 * EWB) + 1));
`else
      check("wide_cycles", 64'(cyc), 64'(WB * 10 + 1));
`endif
      @(negedge clk) busb.go = 1'b0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
